// File: rtl/dmem_access_arbiter_pkg.sv
// Shared encodings and helpers for the data-memory access arbiter.
// load_extend is also usable by the CPU writeback stage.
package dmem_access_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Illegal size, or a halfword/word that is not naturally aligned.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_ILL)
            || ((size == SZ_HALF) && addr_lo[0])
            || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

    // Index of the final byte beat (number of bytes minus one).
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            SZ_HALF: last = 2'd1;
            SZ_WORD: last = 2'd3;
            default: last = 2'd0;
        endcase
        return last;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] size,
                                                input logic sgn);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {{24{sgn & data[7]}}, data[7:0]};
            SZ_HALF: res = {{16{sgn & data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_access_arbiter_rr.sv
// Two-way round-robin grant: ready goes only to the granted valid port while
// the datapath is idle; last_grant remembers the winner of the last handshake.
module dmem_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    logic last_grant;
    logic grant;

    // Contention goes to the port that did not win last time.
    assign grant  = (valid0 && valid1) ? ~last_grant : valid1;
    assign ready0 = rst && idle && valid0 && !grant;
    assign ready1 = rst && idle && valid1 && grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (ready0) begin
            last_grant <= 1'b0;
        end else if (ready1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Arbitrates two load/store ports onto a byte-wide memory, sequencing each
// access one byte per cycle MSB-first and returning one response per request.
module dmem_access_arbiter
    import dmem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [1:0]        req0_size,
    input  logic              req0_signed,
    input  logic [31:0]       req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [1:0]        req1_size,
    input  logic              req1_signed,
    input  logic [31:0]       req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    state_e              state, state_next;
    logic                accept;
    logic                sel_write, sel_signed, sel_err;
    logic [1:0]          sel_size;
    logic [31:0]         sel_addr, sel_wdata;
    logic                unused_addr_bits;

    logic                port_q, write_q, sgn_q, err_q;
    logic [1:0]          size_q, beat_q;
    logic [ADDR_W-1:0]   base_q, addr_hold;
    logic [31:0]         wdata_q, acc_q;
    logic [7:0]          wdata_hold;

    logic                in_access, in_resp;
    logic [1:0]          last, shift;
    logic [ADDR_W-1:0]   beat_addr;
    logic [7:0]          beat_wdata;
    logic [31:0]         rsp_rdata;

    dmem_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .idle   (state == ST_IDLE),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ready0 (req0_ready),
        .ready1 (req1_ready)
    );

    assign accept = req0_ready | req1_ready;

    always_comb begin
        sel_write  = req1_ready ? req1_write  : req0_write;
        sel_size   = req1_ready ? req1_size   : req0_size;
        sel_signed = req1_ready ? req1_signed : req0_signed;
        sel_addr   = req1_ready ? req1_addr   : req0_addr;
        sel_wdata  = req1_ready ? req1_wdata  : req0_wdata;
    end

    assign sel_err          = access_err(sel_size, sel_addr[1:0]);
    assign unused_addr_bits = ^sel_addr[31:ADDR_W];

    assign in_access  = (state == ST_ACCESS);
    assign in_resp    = (state == ST_RESP);
    assign last       = last_beat(size_q);
    assign shift      = last - beat_q;
    assign beat_addr  = base_q + ADDR_W'(beat_q);
    assign beat_wdata = wdata_q[{shift, 3'b000} +: 8];

    // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = sel_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (beat_q == last) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            port_q     <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            sgn_q      <= 1'b0;
            err_q      <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            beat_q     <= '0;
            acc_q      <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                port_q  <= req1_ready;
                write_q <= sel_write;
                size_q  <= sel_size;
                sgn_q   <= sel_signed;
                err_q   <= sel_err;
                base_q  <= sel_addr[ADDR_W-1:0];
                wdata_q <= sel_wdata;
                beat_q  <= '0;
                acc_q   <= '0;
            end else if (in_access) begin
                beat_q     <= beat_q + 2'd1;
                addr_hold  <= beat_addr;
                wdata_hold <= beat_wdata;
                if (!write_q) acc_q <= {acc_q[23:0], mem_rdata};
            end
        end
    end

    // Address and data hold their last driven beat outside ACCESS.
    assign mem_addr  = in_access ? beat_addr  : addr_hold;
    assign mem_wdata = in_access ? beat_wdata : wdata_hold;
    assign mem_we    = in_access && write_q;
    assign mem_re    = in_access && !write_q;

    assign rsp_rdata  = (in_resp && !write_q && !err_q) ? load_extend(acc_q, size_q, sgn_q) : '0;
    assign rsp0_valid = in_resp && !port_q;
    assign rsp1_valid = in_resp && port_q;
    assign rsp0_rdata = port_q ? '0 : rsp_rdata;
    assign rsp1_rdata = port_q ? rsp_rdata : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench: byte memory model plus a request-level reference model
// (memory image, alignment rules, extension, latency and round-robin order).
module tb_dmem_access_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_ready, req0_write = 1'b0, req0_signed = 1'b0;
    logic [1:0]  req0_size = 2'd0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid = 1'b0, req1_ready, req1_write = 1'b0, req1_signed = 1'b0;
    logic [1:0]  req1_size = 2'd0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        write;
        int          n;
        logic [7:0]  base;
        logic [31:0] wdata;
        int          hs_cyc;
        int          we0;
        int          re0;
        int          wl0;
    } exp_t;

    logic [7:0]  tb_mem  [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic        init_req = 1'b1;
    int          we_cnt = 0, re_cnt = 0;
    logic [7:0]  wlog_addr[$], wlog_data[$];

    req_t        q0[$], q1[$];
    exp_t        pend[$];
    int          grant_port_q[$], grant_cyc_q[$], rsp_cyc_q[$];
    logic [31:0] rsp_data_q[$];
    logic        rsp_err_q[$];
    int          tb_last = 1;
    int          vectors = 0, miscompares = 0;

    dmem_access_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_size(req0_size), .req0_signed(req0_signed), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_size(req1_size), .req1_signed(req1_signed), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_err(rsp1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: combinational read, write on the clock edge; logs every strobe.
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'(i * 29 + 7);
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) re_cnt <= re_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic w, input logic [1:0] s, input logic sg,
                                input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.write = w; r.size = s; r.sgn = sg; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // Reference model: applies one accepted request to the memory image.
    task automatic model_accept(input int port, input req_t r, output exp_t e);
        logic [7:0]  a;
        logic [31:0] v;
        int          n;
        a = r.addr[7:0];
        n = 1 << r.size;
        e.port  = port;
        e.write = r.write;
        e.base  = a;
        e.wdata = r.wdata;
        e.err   = (r.size == 2'd3) || (r.size == 2'd1 && a[0]) || (r.size == 2'd2 && a[1:0] != 2'd0);
        e.n     = e.err ? 0 : n;
        e.lat   = e.err ? 1 : n + 1;
        e.rdata = '0;
        if (!e.err && r.write) begin
            for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = 8'(r.wdata >> (8 * (n - 1 - i)));
        end else if (!e.err) begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[8'(a + i)]);
            if (r.sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
        end
    endtask

    // Drives both request queues until drained, checking grants and responses.
    task automatic run(input int budget);
        exp_t e;
        req_t r;
        int   gp, exp_gp;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (q0.size() == 0 && q1.size() == 0 && pend.size() == 0) break;
            req0_valid = (q0.size() != 0);
            if (req0_valid) {req0_write, req0_size, req0_signed, req0_addr, req0_wdata} = q0[0];
            req1_valid = (q1.size() != 0);
            if (req1_valid) {req1_write, req1_size, req1_signed, req1_addr, req1_wdata} = q1[0];
            #2;
            if (rsp0_valid || rsp1_valid) begin
                check("rsp_one_port", 32'(rsp0_valid & rsp1_valid), 0);
                if (pend.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = pend.pop_front();
                    check("rsp_port", rsp1_valid ? 1 : 0, e.port);
                    check("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
                    check("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(e.err));
                    check("rsp_latency", cyc - e.hs_cyc, e.lat);
                    check("we_beats", we_cnt - e.we0, e.write ? e.n : 0);
                    check("re_beats", re_cnt - e.re0, e.write ? 0 : e.n);
                    if (e.write && wlog_addr.size() >= e.wl0 + e.n) begin
                        for (int i = 0; i < e.n; i++) begin
                            check("wr_addr", wlog_addr[e.wl0 + i], 32'(8'(e.base + i)));
                            check("wr_byte", wlog_data[e.wl0 + i], 32'(8'(e.wdata >> (8 * (e.n - 1 - i)))));
                        end
                    end
                    rsp_cyc_q.push_back(cyc);
                    rsp_data_q.push_back(rsp1_valid ? rsp1_rdata : rsp0_rdata);
                    rsp_err_q.push_back(rsp1_valid ? rsp1_err : rsp0_err);
                end
            end
            if (req0_ready || req1_ready) begin
                gp     = req1_ready ? 1 : 0;
                exp_gp = (req0_valid && req1_valid) ? 1 - tb_last : (req1_valid ? 1 : 0);
                check("grant_port", gp, exp_gp);
                check("ready_while_busy", pend.size(), 0);
                if ((gp == 1 && q1.size() != 0) || (gp == 0 && q0.size() != 0)) begin
                    tb_last = gp;
                    r = (gp == 1) ? q1.pop_front() : q0.pop_front();
                    model_accept(gp, r, e);
                    e.hs_cyc = cyc;
                    e.we0    = we_cnt;
                    e.re0    = re_cnt;
                    e.wl0    = wlog_addr.size();
                    pend.push_back(e);
                    grant_port_q.push_back(gp);
                    grant_cyc_q.push_back(cyc);
                end else begin
                    check("ready_without_valid", 1, 0);
                end
            end
            @(posedge clk);
            #1;
        end
        check("run_drained", q0.size() + q1.size() + pend.size(), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic clear_logs();
        grant_port_q.delete(); grant_cyc_q.delete(); rsp_cyc_q.delete();
        rsp_data_q.delete(); rsp_err_q.delete();
    endtask

    initial begin
        req_t        r;
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 29 + 7);
        #3 rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 init_req = 1'b0;

        // Reset state with both ports requesting.
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_ready1", 32'(req1_ready), 0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_re", 32'(mem_re), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_rsp0_err", 32'(rsp0_err), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tb_last = 1;
        @(posedge clk); #1;

        // Word store then loads of several sizes from the same bytes.
        clear_logs();
        q0.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF));
        q0.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0));
        q0.push_back(mk(1'b0, 2'd0, 1'b1, 32'h12, 32'h0));
        q0.push_back(mk(1'b0, 2'd0, 1'b0, 32'h12, 32'h0));
        q0.push_back(mk(1'b0, 2'd1, 1'b1, 32'h10, 32'h0));
        run(100);
        check("sw_rdata", rsp_data_q[0], 32'h0);
        check("sw_latency", rsp_cyc_q[0] - grant_cyc_q[0], 5);
        check("lw_rdata", rsp_data_q[1], 32'hDEAD_BEEF);
        check("lb_rdata", rsp_data_q[2], 32'hFFFF_FFBE);
        check("lbu_rdata", rsp_data_q[3], 32'h0000_00BE);
        check("lh_rdata", rsp_data_q[4], 32'hFFFF_DEAD);

        // Misaligned word and illegal size: one-cycle error, no strobes.
        clear_logs();
        q0.push_back(mk(1'b0, 2'd2, 1'b0, 32'h11, 32'h0));
        q0.push_back(mk(1'b1, 2'd3, 1'b0, 32'h44, 32'hFFFF_FFFF));
        run(40);
        check("misaligned_err", 32'(rsp_err_q[0]), 1);
        check("illegal_err", 32'(rsp_err_q[1]), 1);
        check("illegal_rdata", rsp_data_q[1], 0);

        // Both ports valid from reset release: strict alternation, grant right after each response.
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        q1.push_back(mk(1'b1, 2'd1, 1'b0, 32'h20, 32'h1234));
        q1.push_back(mk(1'b0, 2'd1, 1'b0, 32'h20, 32'h0));
        q1.push_back(mk(1'b1, 2'd0, 1'b0, 32'h22, 32'h55));
        q1.push_back(mk(1'b0, 2'd0, 1'b1, 32'h22, 32'h0));
        q0.push_back(mk(1'b1, 2'd2, 1'b0, 32'h24, 32'h0BAD_F00D));
        q0.push_back(mk(1'b0, 2'd0, 1'b0, 32'h24, 32'h0));
        q0.push_back(mk(1'b1, 2'd1, 1'b0, 32'h26, 32'h8001));
        q0.push_back(mk(1'b0, 2'd1, 1'b1, 32'h26, 32'h0));
        {req0_write, req0_size, req0_signed, req0_addr, req0_wdata} = q0[0];
        {req1_write, req1_size, req1_signed, req1_addr, req1_wdata} = q1[0];
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tb_last = 1;
        rst = 1'b1;
        run(200);
        check("rr_grant_count", grant_port_q.size(), 8);
        for (int k = 0; k < 8; k++) check("rr_order", grant_port_q[k], k % 2);
        for (int k = 1; k < 8; k++) check("rr_gap", grant_cyc_q[k], rsp_cyc_q[k - 1] + 1);
        check("sh_mem_20", 32'(tb_mem[8'h20]), 32'h12);
        check("sh_mem_21", 32'(tb_mem[8'h21]), 32'h34);

        // Reset during the second beat of a word store.
        req0_write = 1'b1; req0_size = 2'd2; req0_signed = 1'b0;
        req0_addr = 32'h30; req0_wdata = 32'hA1B2_C3D4; req0_valid = 1'b1;
        #2 check("rm_ready", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("rm_beat0_addr", 32'(mem_addr), 32'h30);
        @(posedge clk); #1;
        check("rm_beat1_we", 32'(mem_we), 1);
        rst = 1'b0;
        #1;
        check("rm_we_drop", 32'(mem_we), 0);
        check("rm_addr_reset", 32'(mem_addr), 0);
        check("rm_no_rsp", 32'(rsp0_valid), 0);
        ref_mem[8'h30] = 8'hA1;
        @(posedge clk); #1;
        check("rm_no_rsp_later", 32'(rsp0_valid), 0);
        clear_logs();
        q0.push_back(mk(1'b0, 2'd0, 1'b0, 32'h30, 32'h0));
        q1.push_back(mk(1'b0, 2'd0, 1'b0, 32'h31, 32'h0));
        {req0_write, req0_size, req0_signed, req0_addr, req0_wdata} = q0[0];
        {req1_write, req1_size, req1_signed, req1_addr, req1_wdata} = q1[0];
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tb_last = 1;
        rst = 1'b1;
        run(60);
        check("rm_first_grant", grant_port_q[0], 0);
        check("rm_byte30", rsp_data_q[0], 32'hA1);

        // High address bits beyond ADDR_W are ignored.
        clear_logs();
        q0.push_back(mk(1'b1, 2'd0, 1'b0, 32'h1FF, 32'h5A));
        run(20);
        check("wrap_mem_ff", 32'(tb_mem[8'hFF]), 32'h5A);

        // Randomized mixed traffic on both ports.
        for (int k = 0; k < 120; k++) begin
            a   = $urandom();
            sel = $urandom_range(0, 9);
            r   = mk(1'($urandom_range(0, 1)), (sel == 9) ? 2'd3 : 2'(sel / 3),
                     1'($urandom_range(0, 1)), a, $urandom());
            if ($urandom_range(0, 3) != 0) r.addr[1:0] = (r.size == 2'd2) ? 2'b00 : {r.addr[1], 1'b0};
            if ($urandom_range(0, 1) == 1) q1.push_back(r);
            else q0.push_back(r);
        end
        run(4000);

        for (int i = 0; i < DEPTH; i++) check("mem_image", 32'(tb_mem[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
